// File: rtl/operand_fetch.sv
// Operand fetch stage: 4x8 register file with scoreboard, writeback bypass,
// hazard stall and a one-entry output register toward the ALU.
module operand_fetch (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_instr,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] operand_a,
  output logic [7:0] operand_b,
  output logic [2:0] opcode,
  output logic [1:0] out_rd,
  input  logic       wb_en,
  input  logic [1:0] wb_addr,
  input  logic [7:0] wb_data,
  output logic [3:0] pending
);

  localparam int unsigned DataW   = 8;
  localparam int unsigned NumRegs = 4;
  localparam int unsigned AddrW   = 2;
  localparam int unsigned OpW     = 3;

  logic [DataW-1:0]   rf_q [NumRegs];
  logic [DataW-1:0]   rf_d [NumRegs];
  logic [NumRegs-1:0] pending_q, pending_d;
  logic               out_valid_q, out_valid_d;
  logic [DataW-1:0]   op_a_q, op_a_d;
  logic [DataW-1:0]   op_b_q, op_b_d;
  logic [OpW-1:0]     opcode_q, opcode_d;
  logic [AddrW-1:0]   rd_q, rd_d;

  logic [OpW-1:0]     in_op;
  logic [AddrW-1:0]   in_rd, in_rs;
  logic               unused_rsvd;
  logic               unary;
  logic [NumRegs-1:0] wb_mask, eff_pend;
  logic               hazard, accept;
  logic [DataW-1:0]   rd_val, rs_val;

  assign in_op       = in_instr[7:5];
  assign unused_rsvd = in_instr[4];
  assign in_rd       = in_instr[3:2];
  assign in_rs       = in_instr[1:0];

  // Opcodes 101/110/111 take a single source operand.
  assign unary    = in_op[2] & (in_op[1] | in_op[0]);
  assign wb_mask  = wb_en ? (NumRegs'(1) << wb_addr) : '0;
  assign eff_pend = pending_q & ~wb_mask;
  assign hazard   = eff_pend[in_rd] | (~unary & eff_pend[in_rs]);
  assign in_ready = ~rst & (~out_valid_q | out_ready) & ~hazard;
  assign accept   = in_valid & in_ready;

  // Same-cycle writeback forwards straight into the operand read.
  assign rd_val = (wb_en && (wb_addr == in_rd)) ? wb_data : rf_q[in_rd];
  assign rs_val = (wb_en && (wb_addr == in_rs)) ? wb_data : rf_q[in_rs];

  always_comb begin
    rf_d        = rf_q;
    pending_d   = eff_pend;
    out_valid_d = out_valid_q & ~out_ready;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    opcode_d    = opcode_q;
    rd_d        = rd_q;
    if (wb_en) rf_d[wb_addr] = wb_data;
    if (accept) begin
      pending_d[in_rd] = 1'b1;
      out_valid_d      = 1'b1;
      op_a_d           = rd_val;
      op_b_d           = unary ? '0 : rs_val;
      opcode_d         = in_op;
      rd_d             = in_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_q        <= '{default: '0};
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      opcode_q    <= '0;
      rd_q        <= '0;
    end else begin
      rf_q        <= rf_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      opcode_q    <= opcode_d;
      rd_q        <= rd_d;
    end
  end

  assign out_valid = out_valid_q;
  assign operand_a = op_a_q;
  assign operand_b = op_b_q;
  assign opcode    = opcode_q;
  assign out_rd    = rd_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: hand-computed expectations checked with
// immediate assertions after each step.
module tb_operand_fetch;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_instr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic [2:0] opcode;
  logic [1:0] out_rd;
  logic       wb_en;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;
  logic [3:0] pending;

  int checks = 0;
  int errors = 0;

  operand_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .opcode    (opcode),
    .out_rd    (out_rd),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] instr, input logic ordy,
                       input logic wen, input logic [1:0] waddr, input logic [7:0] wdata);
    in_valid  = v;
    in_instr  = instr;
    out_ready = ordy;
    wb_en     = wen;
    wb_addr   = waddr;
    wb_data   = wdata;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] op, input logic [1:0] rd,
                         input logic [3:0] pend);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".a"},     32'(operand_a), 32'(a));
    chk({tag, ".b"},     32'(operand_b), 32'(b));
    chk({tag, ".op"},    32'(opcode),    32'(op));
    chk({tag, ".rd"},    32'(out_rd),    32'(rd));
    chk({tag, ".pend"},  32'(pending),   32'(pend));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00);
    tick();
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk_out("rst", 1'b0, 8'h00, 8'h00, 3'd0, 2'd0, 4'h0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel.in_ready", 32'(in_ready), 32'd1);

    // Preload R1=05, R2=03, R3=77; writes to non-pending regs leave scoreboard alone
    drive(1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 8'h05); tick();
    chk("wb1.pend", 32'(pending), 32'h0);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 2'd2, 8'h03); tick();
    drive(1'b0, 8'h00, 1'b1, 1'b1, 2'd3, 8'h77); tick();

    // ADD rd=1 rs=2
    drive(1'b1, 8'h06, 1'b1, 1'b0, 2'd0, 8'h00); #1;
    chk("add.in_ready", 32'(in_ready), 32'd1);
    tick();
    chk_out("add", 1'b1, 8'h05, 8'h03, 3'd0, 2'd1, 4'b0010);

    // SUB rd=1 rs=2 stalls on pending[1], then a same-cycle writeback releases it
    drive(1'b1, 8'h26, 1'b1, 1'b0, 2'd0, 8'h00); #1;
    chk("sub.stall", 32'(in_ready), 32'd0);
    drive(1'b1, 8'h26, 1'b1, 1'b1, 2'd1, 8'h08); #1;
    chk("sub.release", 32'(in_ready), 32'd1);
    tick();
    chk_out("sub", 1'b1, 8'h08, 8'h03, 3'd1, 2'd1, 4'b0010);

    // MOV-like op rd=3 rs=0 to mark R3 pending
    drive(1'b1, 8'h4C, 1'b1, 1'b0, 2'd0, 8'h00); tick();
    chk_out("op2", 1'b1, 8'h77, 8'h00, 3'd2, 2'd3, 4'b1010);

    // NOT rd=0 rs=3: unary, so pending R3 does not stall and operand_b is 0
    drive(1'b1, 8'hA3, 1'b1, 1'b0, 2'd0, 8'h00); #1;
    chk("not.in_ready", 32'(in_ready), 32'd1);
    tick();
    chk_out("not", 1'b1, 8'h00, 8'h00, 3'd5, 2'd0, 4'b1011);

    // Backpressure for three cycles: outputs hold, nothing accepted
    drive(1'b1, 8'h0A, 1'b0, 1'b0, 2'd0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      tick();
      chk_out("bp", 1'b1, 8'h00, 8'h00, 3'd5, 2'd0, 4'b1011);
    end
    out_ready = 1'b1; #1;
    chk("bp.resume", 32'(in_ready), 32'd1);
    tick();
    chk_out("bp.acc", 1'b1, 8'h03, 8'h03, 3'd0, 2'd2, 4'b1111);

    // Drain via writebacks; out_valid drops after consume with no accept
    drive(1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 8'h10); tick();
    chk("drain.valid", 32'(out_valid), 32'd0);
    chk("drain.pend0", 32'(pending), 32'b1110);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 8'h11); tick();
    drive(1'b0, 8'h00, 1'b1, 1'b1, 2'd2, 8'h12); tick();
    drive(1'b0, 8'h00, 1'b1, 1'b1, 2'd3, 8'h13); tick();
    chk("drain.pend", 32'(pending), 32'h0);

    // Back-to-back independent issues
    drive(1'b1, 8'h01, 1'b1, 1'b0, 2'd0, 8'h00); tick();
    chk_out("b2b0", 1'b1, 8'h10, 8'h11, 3'd0, 2'd0, 4'b0001);
    drive(1'b1, 8'h0B, 1'b1, 1'b0, 2'd0, 8'h00); #1;
    chk("b2b1.in_ready", 32'(in_ready), 32'd1);
    tick();
    chk_out("b2b1", 1'b1, 8'h12, 8'h13, 3'd0, 2'd2, 4'b0101);

    // Build pending=1010 with a live output, clearing R0/R2 by writeback
    drive(1'b1, 8'h05, 1'b1, 1'b1, 2'd0, 8'h30); tick();
    chk("pre.pend", 32'(pending), 32'b0110);
    drive(1'b1, 8'h0F, 1'b1, 1'b1, 2'd2, 8'h31); tick();
    chk_out("pre", 1'b1, 8'h13, 8'h13, 3'd0, 2'd3, 4'b1010);

    // Asynchronous reset mid-cycle
    drive(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.in_ready", 32'(in_ready), 32'd0);
    chk_out("arst", 1'b0, 8'h00, 8'h00, 3'd0, 2'd0, 4'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Register file reads back zero after release
    drive(1'b1, 8'h01, 1'b1, 1'b0, 2'd0, 8'h00); #1;
    chk("post.in_ready", 32'(in_ready), 32'd1);
    tick();
    chk_out("post0", 1'b1, 8'h00, 8'h00, 3'd0, 2'd0, 4'b0001);
    drive(1'b1, 8'h0B, 1'b1, 1'b0, 2'd0, 8'h00); tick();
    chk_out("post1", 1'b1, 8'h00, 8'h00, 3'd0, 2'd2, 4'b0101);

    drive(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00); tick();
    chk("end.valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL provide a single clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1  upstream instruction valid.
REQ-005 in_ready  out  1  instruction accepted on a cycle with in_valid & in_ready.
REQ-006 in_instr  in  8  instruction fields:
- [7:5] opcode
- [4] reserved, ignored
- [3:2] rd
- [1:0] rs
REQ-007 out_valid  out  1  issued operation valid toward the ALU stage.
REQ-008 out_ready  in  1  downstream consumes on out_valid & out_ready.
REQ-009 operand_a  out  8  value of rd at issue.
REQ-010 operand_b  out  8  value of rs at issue; 0 for unary opcodes.
REQ-011 opcode  out  3  ALU opcode, passed through unchanged.
REQ-012 out_rd  out  2  destination register tag for writeback.
REQ-013 wb_en  in  1  writeback strobe from the ALU result path.
REQ-014 wb_addr  in  2  writeback register index.
REQ-015 wb_data  in  8  writeback value.
REQ-016 pending  out  4  scoreboard, one bit per register.

Function
REQ-017 SHALL hold a 4 x 8-bit register file R0..R3, written on any cycle with wb_en: R[wb_addr] <= wb_data.
REQ-018 SHALL treat opcodes 101, 110 and 111 as unary: operand_b is 0 and rs is excluded from the hazard check.
REQ-019 SHALL form the effective pending set as pending & ~(wb_en ? onehot(wb_addr) : 0), so a same-cycle writeback clears its hazard.
REQ-020 SHALL declare a hazard when the effective pending bit of rd is set, or when the opcode is binary and the effective pending bit of rs is set.
REQ-021 in_ready SHALL equal (!out_valid | out_ready) & !hazard; it may depend combinationally on in_instr, wb_en and wb_addr.
REQ-022 On accept, the block SHALL, at the next edge:
- register operand_a, operand_b, opcode and out_rd
- set out_valid
- set pending[rd]
REQ-023 Operand reads SHALL bypass: if wb_en and wb_addr equals the read index in the accept cycle, the operand SHALL use wb_data.
REQ-024 Latency SHALL be exactly 1 cycle from accept to out_valid; throughput SHALL be 1 per cycle when there is no hazard and no backpressure.
REQ-025 While out_valid & !out_ready, all output fields SHALL hold stable.
REQ-026 out_valid SHALL clear after a consume cycle with no new accept.
REQ-027 If a pending bit is set by an accept and cleared by wb_en for the same register in the same cycle, set SHALL win.
REQ-028 wb_en to a non-pending register SHALL write the register file and leave pending unchanged.
REQ-029 in_ready SHALL be 0 whenever the current instruction has a hazard, independent of in_valid.

Reset
REQ-030 While rst is high, the block SHALL hold:
- R0..R3 = 0, pending = 0000
- out_valid = 0, operand_a = 0, operand_b = 0, opcode = 000, out_rd = 00
REQ-031 Reset asserted mid-operation SHALL discard any held output and clear all pending bits immediately, without waiting for a clock edge.
REQ-032 in_ready SHALL be 0 while rst is high, and SHALL be 1 on the first cycle after release when no hazard applies.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
- Writeback R1=0x05 and R2=0x03, then issue ADD rd=1 rs=2 -> next cycle: out_valid=1, operand_a=0x05, operand_b=0x03, opcode=000, out_rd=01, pending=0010.
- Issue SUB rd=1 rs=2 while pending[1]=1 -> in_ready=0. Then wb_en addr=1 data=0x08 in the same cycle -> in_ready=1, operand_a=0x08.
- Issue NOT rd=0 rs=3 with pending[3]=1 -> accepted, operand_b=0x00, rs not stalled.
- out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; out_ready=1 -> new instruction accepted the same cycle.
- Back-to-back independent issues (rd=0 rs=1, then rd=2 rs=3), out_ready=1 -> two consecutive out_valid cycles.
- Assert rst with out_valid=1 and pending=1010 -> out_valid=0 and pending=0000 before the next edge; registers read 0x00 after release.
